// File: rtl/shift_add_mult_seq_if.sv
// Start/done handshake and operand/result bundle between the sequencer (master)
// and the shift-and-add multiplier (slave).
interface shift_add_mult_seq_if #(
    parameter int WIDTH = 4
);
    logic                 st;
    logic                 sgn;
    logic [WIDTH-1:0]     mcand;
    logic [WIDTH-1:0]     mplier;
    logic                 idle;
    logic                 load;
    logic                 ad;
    logic                 sh;
    logic                 done;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output st, sgn, mcand, mplier,
        input  idle, load, ad, sh, done, product
    );

    modport slave (
        input  st, sgn, mcand, mplier,
        output idle, load, ad, sh, done, product
    );
endinterface

// File: rtl/shift_add_mult_seq.sv
// Sequential shift-and-add multiplier, unsigned or two's-complement signed,
// with the control FSM and the {A,Q} accumulator datapath in one block.
module shift_add_mult_seq #(
    parameter int WIDTH = 4
) (
    input logic                 clk,
    input logic                 rst_n,
    shift_add_mult_seq_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CHK, SHF, DONE} state_t;

    state_t               state_reg, state_next;
    // acc = {A[WIDTH:0], Q[WIDTH-1:0]}; A carries a guard bit for carry/sign
    logic [2*WIDTH:0]     acc_reg, acc_next;
    logic [WIDTH-1:0]     b_reg, b_next;
    logic                 sgn_reg, sgn_next;
    logic [CW-1:0]        cnt_reg, cnt_next;
    logic [2*WIDTH-1:0]   product_reg, product_next;

    logic                 idle, load, ad, sh, done;
    logic [2*WIDTH:0]     acc_shifted;
    logic [WIDTH:0]       b_ext;
    logic                 last_bit;

    assign acc_shifted = {(sgn_reg ? acc_reg[2*WIDTH] : 1'b0), acc_reg[2*WIDTH:1]};
    assign b_ext       = sgn_reg ? {b_reg[WIDTH-1], b_reg} : {1'b0, b_reg};
    assign last_bit    = (cnt_reg == CW'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            acc_reg     <= '0;
            b_reg       <= '0;
            sgn_reg     <= 1'b0;
            cnt_reg     <= '0;
            product_reg <= '0;
        end else begin
            state_reg   <= state_next;
            acc_reg     <= acc_next;
            b_reg       <= b_next;
            sgn_reg     <= sgn_next;
            cnt_reg     <= cnt_next;
            product_reg <= product_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        acc_next     = acc_reg;
        b_next       = b_reg;
        sgn_next     = sgn_reg;
        cnt_next     = cnt_reg;
        product_next = product_reg;
        idle         = 1'b0;
        load         = 1'b0;
        ad           = 1'b0;
        sh           = 1'b0;
        done         = 1'b0;

        case (state_reg)
            IDLE: begin
                idle = 1'b1;
                if (bus.st) begin
                    load       = 1'b1;
                    acc_next   = {{(WIDTH + 1){1'b0}}, bus.mplier};
                    b_next     = bus.mcand;
                    sgn_next   = bus.sgn;
                    cnt_next   = '0;
                    state_next = CHK;
                end
            end
            CHK: begin
                if (acc_reg[0]) begin
                    ad = 1'b1;
                    // The multiplier MSB has negative weight in two's complement
                    if (sgn_reg && last_bit)
                        acc_next[2*WIDTH:WIDTH] = acc_reg[2*WIDTH:WIDTH] - b_ext;
                    else
                        acc_next[2*WIDTH:WIDTH] = acc_reg[2*WIDTH:WIDTH] + b_ext;
                    state_next = SHF;
                end else begin
                    sh       = 1'b1;
                    acc_next = acc_shifted;
                    cnt_next = cnt_reg + CW'(1);
                    if (last_bit) begin
                        product_next = acc_shifted[2*WIDTH-1:0];
                        state_next   = DONE;
                    end
                end
            end
            SHF: begin
                sh       = 1'b1;
                acc_next = acc_shifted;
                cnt_next = cnt_reg + CW'(1);
                if (last_bit) begin
                    product_next = acc_shifted[2*WIDTH-1:0];
                    state_next   = DONE;
                end else begin
                    state_next = CHK;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign bus.idle    = idle;
    assign bus.load    = load;
    assign bus.ad      = ad;
    assign bus.sh      = sh;
    assign bus.done    = done;
    assign bus.product = product_reg;
endmodule

// File: tb/tb_shift_add_mult_seq.sv
// Directed bench for the WIDTH=4 shift-and-add multiplier: handshake timing,
// add/shift step pattern, products, restart rules and mid-operation reset.
module tb_shift_add_mult_seq;
    logic clk;
    logic rst_n;
    int   tests  = 0;
    int   failed = 0;

    shift_add_mult_seq_if #(.WIDTH(4)) bus();

    shift_add_mult_seq #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        tests++;
        assert (obs == exp)
        else begin
            failed++;
            $error("FAIL %s: observed %s expected %s", tag, obs, exp);
        end
    endtask

    // One multiply: St for one cycle, then trace A/S steps until Done.
    task automatic do_mult(input string tag, input logic s, input logic [3:0] mc,
                           input logic [3:0] mp, input logic [7:0] exp_prod,
                           input int exp_lat, input string exp_pat, input bit poke);
        int    lat;
        string pat;
        @(negedge clk);
        bus.st = 1'b1; bus.sgn = s; bus.mcand = mc; bus.mplier = mp;
        #1;
        chk({tag, " load"}, 32'(bus.load), 32'd1);
        @(negedge clk);
        // operand changes after Load must not matter
        bus.st = 1'b0; bus.mcand = ~mc; bus.mplier = ~mp; bus.sgn = ~s;
        #1;
        lat = 0;
        pat = "";
        while (!bus.done && lat < 20) begin
            if (bus.ad && bus.sh)  pat = {pat, "X"};
            else if (bus.ad)       pat = {pat, "A"};
            else if (bus.sh)       pat = {pat, "S"};
            else                   pat = {pat, "-"};
            lat++;
            if (poke && lat == 2) begin
                bus.st = 1'b1;
                #1;
                chk({tag, " load_while_busy"}, 32'(bus.load), 32'd0);
            end
            if (poke && lat == 3) bus.st = 1'b0;
            @(negedge clk);
            #1;
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk_str({tag, " pattern"}, pat, exp_pat);
        chk({tag, " product"}, 32'(bus.product), 32'(exp_prod));
        @(negedge clk);
        #1;
        chk({tag, " done_pulse"}, 32'(bus.done), 32'd0);
        chk({tag, " product_hold"}, 32'(bus.product), 32'(exp_prod));
        $display("[TB] %s sgn=%0d %0h*%0h -> product=%02h latency=%0d pattern=%s",
                 tag, s, mc, mp, bus.product, lat, pat);
    endtask

    initial begin
        int loads, dones;
        bus.st = 1'b0; bus.sgn = 1'b0; bus.mcand = '0; bus.mplier = '0;
        rst_n = 1'b0;

        // 1. reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rst idle", 32'(bus.idle), 32'd1);
        chk("rst product", 32'(bus.product), 32'd0);
        chk("rst ctrl", {28'd0, bus.load, bus.ad, bus.sh, bus.done}, 32'd0);
        $display("[TB] reset idle=%0d product=%02h", bus.idle, bus.product);

        // 2-4. unsigned and signed products
        do_mult("u13x11", 1'b0, 4'd13, 4'd11, 8'h8F, 7, "ASASSAS", 1'b0);
        do_mult("u15x15", 1'b0, 4'd15, 4'd15, 8'hE1, 8, "ASASASAS", 1'b0);
        do_mult("u13x0",  1'b0, 4'd13, 4'd0,  8'h00, 4, "SSSS", 1'b0);
        do_mult("s-3x5",  1'b1, 4'hD,  4'h5,  8'hF1, 6, "ASSASS", 1'b0);
        do_mult("s-8x-8", 1'b1, 4'h8,  4'h8,  8'h40, 5, "SSSAS", 1'b0);
        do_mult("s-1x-1", 1'b1, 4'hF,  4'hF,  8'h01, 8, "ASASASAS", 1'b0);

        // 5. St while busy is ignored
        do_mult("u13x11_poke", 1'b0, 4'd13, 4'd11, 8'h8F, 7, "ASASSAS", 1'b1);

        // 5. St held high: 3*5 takes 8 cycles from Load to Load
        loads = 0;
        dones = 0;
        @(negedge clk);
        bus.st = 1'b1; bus.sgn = 1'b0; bus.mcand = 4'd3; bus.mplier = 4'd5;
        for (int i = 0; i < 24; i++) begin
            #1;
            if (bus.load) loads++;
            if (bus.done) begin
                dones++;
                chk("b2b product", 32'(bus.product), 32'h0F);
            end
            if (bus.ad && bus.sh) chk("b2b ad_sh_exclusive", 32'd1, 32'd0);
            @(negedge clk);
        end
        bus.st = 1'b0;
        chk("b2b loads", 32'(loads), 32'd3);
        chk("b2b dones", 32'(dones), 32'd3);
        $display("[TB] back-to-back loads=%0d dones=%0d", loads, dones);

        // 6. reset mid-operation
        @(negedge clk);
        bus.st = 1'b1; bus.sgn = 1'b0; bus.mcand = 4'd15; bus.mplier = 4'd15;
        @(negedge clk);
        bus.st = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("midrst idle", 32'(bus.idle), 32'd1);
        chk("midrst product", 32'(bus.product), 32'd0);
        chk("midrst done", 32'(bus.done), 32'd0);
        $display("[TB] mid-op reset idle=%0d product=%02h", bus.idle, bus.product);
        do_mult("u15x15_after_rst", 1'b0, 4'd15, 4'd15, 8'hE1, 8, "ASASASAS", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
